// File: rtl/sram_ctrl_pkg.sv
// Shared sizes, state encoding and the read-credit helper for the port-0 SRAM controller.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W     = 9;
  localparam int SRAM_DATA_W     = 32;
  localparam int SRAM_NUM_WMASKS = 4;
  localparam int RSP_FIFO_DEPTH  = 2;
  localparam int RSP_CNT_W       = $clog2(RSP_FIFO_DEPTH + 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  // A slot freed by this cycle's pop counts as free, so reads can stream at one per cycle.
  function automatic logic read_credit_ok(input logic [RSP_CNT_W-1:0] count,
                                          input logic                 inflight,
                                          input logic                 pop);
    logic [RSP_CNT_W:0] used;
    used = {1'b0, count} + {{RSP_CNT_W{1'b0}}, inflight} - {{RSP_CNT_W{1'b0}}, pop};
    return used < (RSP_CNT_W + 1)'(RSP_FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry synchronous response FIFO holding captured SRAM read data until the consumer takes it.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [RSP_CNT_W-1:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [RSP_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [RSP_CNT_W-1:0]  count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + RSP_CNT_W'(1);
      2'b01:   count_d = count_q - RSP_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == RSP_CNT_W'(RSP_FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_port0_ctrl.sv
// Port-0 (RW) initiator for the sky130 1rw1r SRAM macro: request stream to macro pins,
// buffered read responses, and an optional zero-fill of the array after reset.
module sram_port0_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = SRAM_ADDR_W,
  parameter int DATA_WIDTH     = SRAM_DATA_W,
  parameter int NUM_WMASKS     = SRAM_NUM_WMASKS,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST    = '1;
  localparam ctrl_state_e           RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  inflight_q, inflight_d;
  logic                  init_done_q, init_done_d;

  logic [RSP_CNT_W-1:0]  fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  req_accept;

  // The macro holds dout0 past the edge, so the read in flight is captured on the following edge.
  assign fifo_push  = inflight_q;
  assign rsp_valid  = !fifo_empty;
  assign fifo_pop   = rsp_valid && rsp_ready;
  assign req_ready  = !rst && (state_q == ST_RUN) &&
                      (req_we || read_credit_ok(fifo_count, inflight_q, fifo_pop));
  assign req_accept = req_valid && req_ready;
  assign init_done  = init_done_q;

  sram_rsp_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rsp_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (dout0),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty),
    .dout (rsp_rdata)
  );

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    init_done_d = init_done_q;
    inflight_d  = req_accept && !req_we;
    if (state_q == ST_INIT) begin
      if (clr_addr_q == CLR_LAST) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end else begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      clr_addr_q  <= '0;
      inflight_q  <= 1'b0;
      init_done_q <= !CLEAR_ON_RESET;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      inflight_q  <= inflight_d;
      init_done_q <= init_done_d;
    end
  end

  // Pins are combinational so the macro samples this cycle's request on the same edge.
  always_comb begin
    csb0   = 1'b1;
    web0   = 1'b1;
    wmask0 = '0;
    addr0  = '0;
    din0   = '0;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          csb0   = 1'b0;
          web0   = 1'b0;
          wmask0 = '1;
          addr0  = clr_addr_q;
          din0   = '0;
        end
        ST_RUN: begin
          csb0   = !req_accept;
          web0   = !req_we;
          wmask0 = req_wmask;
          addr0  = req_addr;
          din0   = req_wdata;
        end
        default: begin
          csb0 = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_push && fifo_full));
      assert (!(fifo_pop && fifo_empty));
    end
  end

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Directed bench for sram_port0_ctrl with a behavioural model of the 1rw1r macro's port 0.
module tb_sram_port0_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_wmask;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        init_done;
  logic        csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [8:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sram_port0_ctrl #(
    .ADDR_WIDTH    (9),
    .DATA_WIDTH    (32),
    .NUM_WMASKS    (4),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_wmask(req_wmask),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .csb0     (csb0),
    .web0     (web0),
    .wmask0   (wmask0),
    .addr0    (addr0),
    .din0     (din0),
    .dout0    (dout0)
  );

  // Macro model: pins sampled on the rising edge, array access and dout0 update on the falling edge.
  logic [31:0] mem [0:511];
  logic        lat_csb = 1'b1;
  logic        lat_web = 1'b1;
  logic [3:0]  lat_mask;
  logic [8:0]  lat_addr;
  logic [31:0] lat_din;

  always @(posedge clk) begin
    lat_csb  <= csb0;
    lat_web  <= web0;
    lat_mask <= wmask0;
    lat_addr <= addr0;
    lat_din  <= din0;
  end

  always @(negedge clk) begin
    if (!lat_csb) begin
      if (!lat_web) begin
        for (int b = 0; b < 4; b++) begin
          if (lat_mask[b]) mem[lat_addr][b*8 +: 8] = lat_din[b*8 +: 8];
        end
      end else begin
        dout0 = mem[lat_addr];
      end
    end
  end

  function automatic logic [31:0] pattern(input int i);
    return 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [3:0] mask,
                               input logic [8:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    req_valid = v;
    req_we    = we;
    req_wmask = mask;
    req_addr  = addr;
    req_wdata = data;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
  endtask

  task automatic waitRsp(output int lat, output logic [31:0] data);
    lat  = 0;
    data = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        data = rsp_rdata;
        break;
      end
    end
  endtask

  task automatic waitInit(output int cycles, output int ready_seen, output logic [46:0] snap);
    cycles     = 0;
    ready_seen = 0;
    snap       = 'x;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (init_done) break;
      if (cycles == 9) snap = {csb0, web0, wmask0, addr0, din0};
      cycles++;
      if (req_ready) ready_seen++;
    end
  endtask

  task automatic streamReads(input int n, input logic [8:0] base, input bit expect_zero,
                             output int drops, output int rcv, output int bad);
    drops = 0;
    rcv   = 0;
    bad   = 0;
    for (int k = 0; k < n + 20 && rcv < n; k++) begin
      @(posedge clk);
      #1;
      req_valid = (k < n);
      req_we    = 1'b0;
      req_wmask = 4'h0;
      req_addr  = base + 9'(k);
      req_wdata = 32'h0;
      @(negedge clk);
      if (k < n && !req_ready) drops++;
      if (rsp_valid) begin
        if (rsp_rdata !== (expect_zero ? 32'h0 : pattern(rcv))) bad++;
        rcv++;
      end
    end
    idle();
  endtask

  initial begin
    int          lat;
    int          cycles;
    int          ready_seen;
    int          drops;
    int          rcv;
    int          bad;
    logic [31:0] data;
    logic [46:0] snap;

    for (int i = 0; i < 512; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    dout0     = 32'h0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wmask = 4'h0;
    req_addr  = 9'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b1;

    // Reset state and clear sequence
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {61'h0, init_done, req_ready, rsp_valid}, 64'h0);
    checkOutput("reset_pins", {17'h0, csb0, web0, wmask0, addr0, din0}, {17'h0, 1'b1, 1'b1, 4'h0, 9'h0, 32'h0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    waitInit(cycles, ready_seen, snap);
    checkOutput("init_cycles", 64'(cycles), 64'd512);
    checkOutput("init_ready_low", 64'(ready_seen), 64'd0);
    checkOutput("clear_pins", {17'h0, snap}, {17'h0, 1'b0, 1'b0, 4'hF, 9'd9, 32'h0});
    checkOutput("ready_after_init", {63'h0, req_ready}, 64'h1);

    applyStimulus(1'b1, 1'b0, 4'h0, 9'h1FF, 32'h0);
    idle();
    waitRsp(lat, data);
    checkOutput("read_1ff_cleared", {32'h0, data}, 64'h0);

    // Write then read same address on the next cycle
    applyStimulus(1'b1, 1'b1, 4'hF, 9'h005, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 4'h0, 9'h005, 32'h0);
    idle();
    waitRsp(lat, data);
    checkOutput("wr_rd_latency", 64'(lat), 64'd2);
    checkOutput("wr_rd_data", {32'h0, data}, {32'h0, 32'hDEAD_BEEF});

    // Partial byte mask merge
    applyStimulus(1'b1, 1'b1, 4'b0101, 9'h005, 32'h1122_3344);
    applyStimulus(1'b1, 1'b0, 4'h0, 9'h005, 32'h0);
    idle();
    waitRsp(lat, data);
    checkOutput("wmask_merge", {32'h0, data}, {32'h0, 32'hDE22_BE44});

    // Backpressure: two reads fit, the third waits for a pop
    applyStimulus(1'b1, 1'b1, 4'hF, 9'h010, 32'hAAAA_0010);
    applyStimulus(1'b1, 1'b1, 4'hF, 9'h011, 32'hBBBB_0011);
    applyStimulus(1'b1, 1'b1, 4'hF, 9'h012, 32'hCCCC_0012);
    idle();
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'h0, 9'h010, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 9'h011, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 9'h012, 32'h0);
    @(negedge clk);
    checkOutput("bp_ready_low", {63'h0, req_ready}, 64'h0);
    checkOutput("bp_csb_idle", {63'h0, csb0}, 64'h1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_full_state", {30'h0, req_ready, csb0, rsp_valid, rsp_rdata}, {30'h0, 1'b0, 1'b1, 1'b1, 32'hAAAA_0010});
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_ready_released", {63'h0, req_ready}, 64'h1);
    idle();
    waitRsp(lat, data);
    checkOutput("bp_second_rsp", {32'h0, data}, {32'h0, 32'hBBBB_0011});
    waitRsp(lat, data);
    checkOutput("bp_third_rsp", {32'h0, data}, {32'h0, 32'hCCCC_0012});

    // Streaming reads at full rate
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 1'b1, 4'hF, 9'h040 + 9'(i), pattern(i));
    streamReads(64, 9'h040, 1'b0, drops, rcv, bad);
    checkOutput("stream_drops", 64'(drops), 64'd0);
    checkOutput("stream_count", 64'(rcv), 64'd64);
    checkOutput("stream_data_errs", 64'(bad), 64'd0);

    // Reset in the middle of the clear, then a full restart
    applyStimulus(1'b1, 1'b1, 4'hF, 9'h100, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b1, 4'hF, 9'h1FF, 32'h1234_5678);
    idle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (128) @(posedge clk);
    #2;
    checkOutput("midclear_addr", {55'h0, csb0, addr0}, {55'h0, 1'b0, 9'h080});
    rst = 1'b1;
    #1;
    checkOutput("midclear_pins_idle", {17'h0, csb0, web0, wmask0, addr0, din0}, {17'h0, 1'b1, 1'b1, 4'h0, 9'h0, 32'h0});
    checkOutput("midclear_outputs", {61'h0, init_done, req_ready, rsp_valid}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    waitInit(cycles, ready_seen, snap);
    checkOutput("reinit_cycles", 64'(cycles), 64'd512);
    checkOutput("reinit_ready_low", 64'(ready_seen), 64'd0);
    streamReads(512, 9'h000, 1'b1, drops, rcv, bad);
    checkOutput("reclear_count", 64'(rcv), 64'd512);
    checkOutput("reclear_nonzero", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
